// File: rtl/flt2int_pkg.sv
// Shared types and constants for the 16-bit float to sign-magnitude integer converter.
package flt2int_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        SHIFT,
        ROUND,
        WR_HI,
        WR_LO
    } state_t;

    localparam int unsigned EXP_W        = 5;
    localparam int unsigned MAN_W        = 10;
    localparam int unsigned BIAS         = 15;
    localparam int unsigned EXP_SAT      = 30;
    localparam int unsigned EXP_ZERO_MAX = 13;
    localparam int unsigned ACC_W        = 15;
    // Exponent at which {1,m} already sits at integer weight (no shift needed).
    localparam int unsigned EXP_UNIT     = BIAS + MAN_W;

    localparam logic [ACC_W-1:0] MAG_MAX = 15'h7FFF;

endpackage

// File: rtl/flt2int_round.sv
// Round-to-nearest-even on the aligned significand, given the guard and sticky bits.
module flt2int_round
    import flt2int_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic             guard,
    input  logic             sticky,
    output logic [ACC_W-1:0] mag
);

    logic inc;

    always_comb begin
        inc = guard & (sticky | acc[0]);
        mag = acc + {{(ACC_W-1){1'b0}}, inc};
    end

endmodule

// File: rtl/flt2int.sv
// Reads a half-precision float from data_mem and writes back a 16-bit sign-magnitude integer.
// Defining FLT2INT_BARREL_EN replaces the iterative SHIFT state with a single-cycle shifter.
module flt2int
    import flt2int_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd5,
    parameter logic [7:0] DST_ADDR = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] DataAddress,
    output logic       ReadMem,
    output logic       WriteMem,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut
);

    state_t state_q, state_d;

    logic [7:0]       f_hi_q;
    logic             sign_q;
    logic [ACC_W-1:0] mag_q;
    logic [ACC_W-1:0] acc_q;
    logic             guard_q;
    logic             sticky_q;
    logic             done_q;

    // Decode of the float as it completes in RD_LO: high byte registered, low byte live.
    logic [15:0]      f_w;
    logic [EXP_W-1:0] exp_w;
    logic [MAN_W:0]   sig_w;
    logic             is_zero, is_sat, is_small, is_special;
    logic             shift_left;
    logic [3:0]       shift_amt;
    logic [ACC_W-1:0] acc_init;
    logic             guard_init;
    logic             sticky_init;
    logic [ACC_W-1:0] mag_rnd;

    always_comb begin
        f_w        = {f_hi_q, DataOut};
        exp_w      = f_w[14:10];
        sig_w      = {1'b1, f_w[MAN_W-1:0]};
        is_zero    = (exp_w == '0);
        is_sat     = (exp_w >= EXP_W'(EXP_SAT));
        is_small   = (exp_w <= EXP_W'(EXP_ZERO_MAX));
        is_special = is_zero | is_sat | is_small;
        shift_left = (exp_w > EXP_W'(EXP_UNIT));
        shift_amt  = shift_left ? 4'(exp_w - EXP_W'(EXP_UNIT))
                                : 4'(EXP_W'(EXP_UNIT) - exp_w);
    end

`ifdef FLT2INT_BARREL_EN
    logic [2*MAN_W+1:0] rsh_w;

    always_comb begin
        rsh_w = {sig_w, {(MAN_W+1){1'b0}}} >> shift_amt;
        if (shift_left) begin
            acc_init    = ACC_W'(sig_w) << shift_amt;
            guard_init  = 1'b0;
            sticky_init = 1'b0;
        end else begin
            acc_init    = ACC_W'(rsh_w[2*MAN_W+1:MAN_W+1]);
            guard_init  = rsh_w[MAN_W];
            sticky_init = |rsh_w[MAN_W-1:0];
        end
    end
`else
    logic       left_q;
    logic [3:0] cnt_q;

    always_comb begin
        acc_init    = ACC_W'(sig_w);
        guard_init  = 1'b0;
        sticky_init = 1'b0;
    end
`endif

    flt2int_round u_round (
        .acc    (acc_q),
        .guard  (guard_q),
        .sticky (sticky_q),
        .mag    (mag_rnd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = RD_HI;
            RD_HI: state_d = RD_LO;
            RD_LO: begin
                if (is_special) begin
                    state_d = WR_HI;
                end else begin
`ifdef FLT2INT_BARREL_EN
                    state_d = ROUND;
`else
                    state_d = (shift_amt != 4'd0) ? SHIFT : ROUND;
`endif
                end
            end
`ifndef FLT2INT_BARREL_EN
            SHIFT: if (cnt_q == 4'd1) state_d = ROUND;
`endif
            ROUND: state_d = WR_HI;
            WR_HI: state_d = WR_LO;
            WR_LO: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_hi_q   <= '0;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
`ifndef FLT2INT_BARREL_EN
            left_q   <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE:  if (start) done_q <= 1'b0;
                RD_HI: f_hi_q <= DataOut;
                RD_LO: begin
                    sign_q <= f_w[15];
                    if (is_zero || is_small) begin
                        mag_q <= '0;
                    end else if (is_sat) begin
                        mag_q <= MAG_MAX;
                    end else begin
                        acc_q    <= acc_init;
                        guard_q  <= guard_init;
                        sticky_q <= sticky_init;
`ifndef FLT2INT_BARREL_EN
                        left_q   <= shift_left;
                        cnt_q    <= shift_amt;
`endif
                    end
                end
`ifndef FLT2INT_BARREL_EN
                SHIFT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (left_q) begin
                        acc_q <= acc_q << 1;
                    end else begin
                        acc_q    <= acc_q >> 1;
                        guard_q  <= acc_q[0];
                        sticky_q <= sticky_q | guard_q;
                    end
                end
`endif
                ROUND: mag_q <= mag_rnd;
                WR_LO: done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        DataAddress = 8'd0;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataIn      = 8'd0;
        case (state_q)
            RD_HI: begin
                DataAddress = SRC_ADDR;
                ReadMem     = 1'b1;
            end
            RD_LO: begin
                DataAddress = SRC_ADDR + 8'd1;
                ReadMem     = 1'b1;
            end
            WR_HI: begin
                DataAddress = DST_ADDR;
                DataIn      = {sign_q, mag_q[14:8]};
                WriteMem    = 1'b1;
            end
            WR_LO: begin
                DataAddress = DST_ADDR + 8'd1;
                DataIn      = mag_q[7:0];
                WriteMem    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flt2int.sv
// Self-checking bench for flt2int: behavioural data_mem, scoreboard of expected memory images.
module tb_flt2int;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'd0;
    logic [7:0] tb_data = 8'd0;
    int         n_wr = 0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    flt2int #(
        .SRC_ADDR (8'd5),
        .DST_ADDR (8'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut)
    );

    assign DataOut = mem[DataAddress];

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (WriteMem) begin
            mem[DataAddress] <= DataIn;
            n_wr <= n_wr + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Independent reference: exact integer RNE of the float value.
    function automatic logic [15:0] ref_conv(input logic [15:0] f);
        int e, v, k, q, r, h, mag;
        e = int'(f[14:10]);
        v = 1024 + int'(f[9:0]);
        if (e <= 13) mag = 0;
        else if (e >= 30) mag = 32767;
        else if (e >= 25) mag = v << (e - 25);
        else begin
            k = 25 - e;
            q = v >> k;
            r = v - (q << k);
            h = 1 << (k - 1);
            if (r > h || (r == h && (q % 2) == 1)) q++;
            mag = q;
        end
        return {f[15], 15'(mag)};
    endfunction

    function automatic int lat_of(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e <= 13 || e >= 30) return 4;
`ifdef FLT2INT_BARREL_EN
        return 5;
`else
        return (e > 25) ? 5 + (e - 25) : 5 + (25 - e);
`endif
    endfunction

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        bit got, ovl;
        lat = 0; got = 0; ovl = 0;
        while (lat < 200 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (ReadMem && WriteMem) ovl = 1;
            if (done) got = 1;
        end
        check({tag, "_latency"}, got ? lat : -1, exp_lat);
        check({tag, "_rw_overlap"}, 32'(ovl), 0);
    endtask

    task automatic convert(input string tag, input logic [15:0] f, input logic [15:0] exp);
        logic [15:0] e;
        poke(8'd5, f[15:8]);
        poke(8'd6, f[7:0]);
        poke(8'd1, 8'hAA);
        poke(8'd2, 8'hAA);
        exp_q.push_back(exp);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_done"}, {busy, done}, 2'b10);
        wait_done(tag, lat_of(f));
        e = exp_q.pop_front();
        check({tag, "_result"}, {mem[1], mem[2]}, e);
        check({tag, "_idle_mem"}, {busy, ReadMem, WriteMem}, 3'b000);
    endtask

    initial begin
        int w0;
        logic [15:0] r;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, ReadMem, WriteMem, DataAddress, DataIn}, 0);
        @(negedge clk) reset = 1'b1;

        convert("one",      16'h3C00, 16'h0001);
        convert("neg_five", 16'hC500, 16'h8005);
        convert("left4",    16'h77FF, 16'h7FF0);
        convert("half",     16'h3800, 16'h0000);
        convert("one_5",    16'h3E00, 16'h0002);
        convert("two_5",    16'h4100, 16'h0002);
        convert("one_25",   16'h3D00, 16'h0001);
        convert("max_fin",  16'h7BFF, 16'h7FFF);
        convert("neg_inf",  16'hFC00, 16'hFFFF);
        convert("neg_zero", 16'h8000, 16'h8000);
        convert("denorm",   16'h0001, 16'h0000);
        convert("e13",      16'h3400, 16'h0000);
        convert("unit",     16'h6400, 16'h0400);
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom_range(16'h3800, 16'h7BFF));
            r[15] = 1'($urandom);
            convert($sformatf("rand%0d", i), r, ref_conv(r));
        end

        // Reset in the middle of a conversion: nothing may be written.
        poke(8'd5, 8'h3C);
        poke(8'd6, 8'h00);
        poke(8'd1, 8'h5A);
        poke(8'd2, 8'hA5);
        w0 = n_wr;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_outputs", {busy, done, ReadMem, WriteMem, DataAddress, DataIn}, 0);
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_mem", {mem[1], mem[2]}, 16'h5AA5);
        check("midreset_writes", n_wr - w0, 0);
        check("midreset_done", {busy, done}, 2'b00);

        // start pulsed while busy must be ignored.
        poke(8'd5, 8'hC5);
        poke(8'd6, 8'h00);
        w0 = n_wr;
        exp_q.push_back(16'h8005);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start", lat_of(16'hC500) - 3);
        check("busy_start_result", {mem[1], mem[2]}, exp_q.pop_front());
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_held", {busy, done}, 2'b01);
        check("busy_start_writes", n_wr - w0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
